adder_share_sched: RTL and testbench

//  Time-shares one WIDTH-bit adder (sum plus bit-0/bit-1 flags p, q) among N_REQ requesters.

---
 rtl/adder_sched_pkg.sv | 19 +
 rtl/adder_share_sched_rr_arbiter.sv | 31 +++
 rtl/adder_share_sched.sv | 119 +++++++++++
 tb/tb_adder_share_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - scheduler state encoding and default sizes shared by the shared-adder block
package adder_sched_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // 2'd3 is never entered on purpose; the FSM falls back to IDLE from it
   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_ADD  = ADD,
      S_RESP = RESP,
      S_BAD  = 2'd3
   } state_t;

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// rtl/adder_share_sched_rr_arbiter.sv - combinational round-robin pick starting just above the last grant
module rr_arbiter
   import adder_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_idx
);

   logic w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      // offsets 1..N_REQ wrap back to `last` itself, so a lone requester can be re-granted
      for (int k = 1; k <= N_REQ; k++) begin
         if (en && !w_found && req[(int'(last) + k) % N_REQ]) begin
            w_found                              = 1'b1;
            grant[(int'(last) + k) % N_REQ]      = 1'b1;
            grant_idx                            = IDW'((int'(last) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - one WIDTH-bit adder time-shared among N_REQ requesters
// Round-robin grant in IDLE, add in ADD, hold the registered response in RESP until accepted.
module adder_share_sched
   import adder_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_sum,
   output logic                   rsp_carry,
   output logic                   rsp_p,
   output logic                   rsp_q,
   output logic                   busy
);

   state_t           r_state;
   state_t           w_next;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_p;
   logic             r_q;
   logic             r_rsp_valid;

   logic [N_REQ-1:0] w_grant;
   logic [IDW-1:0]   w_gidx;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [WIDTH:0]   w_full;
   logic             w_arb_en;
   logic             w_take;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_arb (
      .req       (req_valid),
      .last      (r_last),
      .en        (w_arb_en),
      .grant     (w_grant),
      .grant_idx (w_gidx)
   );

   assign w_sel_a = req_a[int'(w_gidx) * WIDTH +: WIDTH];
   assign w_sel_b = req_b[int'(w_gidx) * WIDTH +: WIDTH];
   assign w_full  = {1'b0, r_a} + {1'b0, r_b};

   always_comb begin
      w_next   = r_state;
      w_arb_en = 1'b0;
      w_take   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_arb_en = 1'b1;
            if (|req_valid) begin
               w_take = 1'b1;
               w_next = S_ADD;
            end
         end
         S_ADD:  w_next = S_RESP;
         S_RESP: if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= IDW'(N_REQ - 1);
         r_id        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_p         <= 1'b0;
         r_q         <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_rsp_valid <= (w_next == S_RESP);
         if (w_take) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_id   <= w_gidx;
            r_last <= w_gidx;
         end
         // flags come from the freshly computed sum so they can never lag a transaction
         if (r_state == S_ADD) begin
            r_sum   <= w_full[WIDTH-1:0];
            r_carry <= w_full[WIDTH];
            r_p     <= w_full[0];
            r_q     <= w_full[1];
         end
      end
   end

   assign req_ready = w_grant;
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign rsp_carry = r_carry;
   assign rsp_p     = r_p;
   assign rsp_q     = r_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - self-checking bench for adder_share_sched
module tb_adder_share_sched;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_carry;
   logic           rsp_p;
   logic           rsp_q;
   logic           busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   adder_share_sched #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .rsp_p     (rsp_p),
      .rsp_q     (rsp_q),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int oh2idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // transaction-level reference: at most one outstanding add, response due two cycles after its grant
   int m_out = 0, m_gcyc = 0, m_last = N - 1, m_after_rst = 0;
   int m_id = 0, m_sum = 0, m_carry = 0, m_p = 0, m_q = 0;
   int m_pick, m_exp_grant, m_exp_rv, m_a, m_b;

   always @(negedge clk) begin
      if (rst) begin
         m_out       = 0;
         m_last      = N - 1;
         m_after_rst = 1;
      end else begin
         if (m_after_rst != 0) begin
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_rsp_sum", int'(rsp_sum), 0);
            chk("rst_rsp_flags", int'({rsp_carry, rsp_p, rsp_q}), 0);
            m_after_rst = 0;
         end
         m_exp_rv    = (m_out != 0 && cyc - m_gcyc >= 2) ? 1 : 0;
         m_exp_grant = 0;
         m_pick      = -1;
         if (m_out == 0 && req_valid != '0) begin
            m_pick      = rr_pick(req_valid, m_last);
            m_exp_grant = 1 << m_pick;
         end
         chk("model_req_ready", int'(req_ready), m_exp_grant);
         chk("model_busy", int'(busy), m_out);
         chk("model_rsp_valid", int'(rsp_valid), m_exp_rv);
         if (m_exp_rv != 0 && rsp_valid) begin
            chk("model_rsp_id", int'(rsp_id), m_id);
            chk("model_rsp_sum", int'(rsp_sum), m_sum);
            chk("model_rsp_carry", int'(rsp_carry), m_carry);
            chk("model_rsp_p", int'(rsp_p), m_p);
            chk("model_rsp_q", int'(rsp_q), m_q);
         end
         if (m_pick >= 0) begin
            m_a     = int'(req_a[m_pick*W +: W]);
            m_b     = int'(req_b[m_pick*W +: W]);
            m_out   = 1;
            m_gcyc  = cyc;
            m_last  = m_pick;
            m_id    = m_pick;
            m_sum   = (m_a + m_b) % (1 << W);
            m_carry = (m_a + m_b >= (1 << W)) ? 1 : 0;
            m_p     = m_sum % 2;
            m_q     = (m_sum / 2) % 2;
         end else if (m_exp_rv != 0 && rsp_ready) begin
            m_out = 0;
         end
      end
   end

   task automatic set_op(input int i, input int a, input int b);
      logic [W-1:0] va, vb;
      va = W'(a);
      vb = W'(b);
      req_a[i*W +: W] = va;
      req_b[i*W +: W] = vb;
   endtask

   task automatic wait_grant(output int idx, output int gc);
      idx = -1;
      gc  = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            idx = oh2idx(req_ready);
            gc  = cyc;
            return;
         end
      end
      chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output int rc);
      rc = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rc = cyc;
            return;
         end
      end
      chk("rsp_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int g, gc, rc;
   int order[5];
   int gcs[5];
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_req_ready", int'(req_ready), 0);

      // single request, then latency and flags
      set_op(0, 1, 2);
      req_valid = 4'b0001;
      wait_grant(g, gc);
      chk("t1_grant", g, 0);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);
      chk("t1_latency", rc - gc, 2);
      chk("t1_sum", int'(rsp_sum), 3);
      chk("t1_carry", int'(rsp_carry), 0);
      chk("t1_pq", int'({rsp_p, rsp_q}), 3);
      chk("t1_id", int'(rsp_id), 0);

      // zero sum right after a response with p=q=1
      @(posedge clk); #1;
      set_op(1, 0, 0);
      req_valid = 4'b0010;
      wait_grant(g, gc);
      chk("t6_grant", g, 1);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);
      chk("t6_sum", int'(rsp_sum), 0);
      chk("t6_flags", int'({rsp_carry, rsp_p, rsp_q}), 0);

      // overflow wraps and sets carry
      @(posedge clk); #1;
      set_op(2, 14, 3);
      req_valid = 4'b0100;
      wait_grant(g, gc);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);
      chk("t2_id", int'(rsp_id), 2);
      chk("t2_sum", int'(rsp_sum), 1);
      chk("t2_carry", int'(rsp_carry), 1);
      chk("t2_p", int'(rsp_p), 1);
      chk("t2_q", int'(rsp_q), 0);

      // round-robin with everyone valid
      do_reset();
      set_op(0, 3, 4);
      set_op(1, 15, 15);
      set_op(2, 8, 8);
      set_op(3, 6, 5);
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(order[i], gcs[i]);
         chk("t3_order", order[i], exp_order[i]);
         if (i > 0) chk("t3_spacing", gcs[i] - gcs[i-1], 3);
      end
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);

      // backpressure holds the response and blocks new grants
      @(posedge clk); #1;
      set_op(0, 9, 9);
      set_op(1, 5, 6);
      req_valid = 4'b0011;
      rsp_ready = 1'b0;
      wait_grant(g, gc);
      chk("t4_grant", g, 1);
      wait_rsp(rc);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("t4_hold_sum", int'(rsp_sum), 11);
         chk("t4_hold_id", int'(rsp_id), 1);
         chk("t4_hold_ready", int'(req_ready), 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_no_overlap", int'(req_ready), 0);
      @(negedge clk);
      chk("t4_next_grant", int'(req_ready), 1);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);
      chk("t4_second_sum", int'({rsp_carry, rsp_sum}), 18);

      // reset while the add is in flight drops it and restores requester-0 priority
      @(posedge clk); #1;
      set_op(2, 7, 7);
      set_op(1, 3, 4);
      set_op(3, 1, 1);
      req_valid = 4'b0100;
      wait_grant(g, gc);
      chk("t5_first_grant", g, 2);
      @(posedge clk); #1;
      chk("t5_in_add", int'(busy), 1);
      rst = 1'b1;
      req_valid = 4'b1010;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_rsp_valid", int'(rsp_valid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_sum", int'(rsp_sum), 0);
      chk("t5_grant", int'(req_ready), 2);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(rc);
      chk("t5_rsp_id", int'(rsp_id), 1);
      chk("t5_rsp_sum", int'(rsp_sum), 7);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
